// File: rtl/stream_arbiter.sv
// Packet-aware round-robin arbiter: N valid/ready streams into one registered output, locked to a port until its last beat.
// 1-cycle latency; in_ready = load && grant, so a stalled output register stalls every input.
module stream_arbiter #(
    parameter  int DATA_SIZE = 8,
    parameter  int N_PORTS   = 4,
    localparam int IDX_W     = $clog2(N_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_PORTS*DATA_SIZE-1:0] in_data,
    input  logic [N_PORTS-1:0]           in_valid,
    input  logic [N_PORTS-1:0]           in_last,
    output logic [N_PORTS-1:0]           in_ready,
    output logic [DATA_SIZE-1:0]         out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [IDX_W-1:0]             out_port,
    input  logic                         out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [DATA_SIZE-1:0]   out_data_q;
    logic                   out_valid_q;
    logic                   out_last_q;
    logic [IDX_W-1:0]       out_port_q;

    logic [N_PORTS-1:0]     grant;
    logic [IDX_W-1:0]       sel;
    logic                   found;
    logic [IDX_W:0]         cand_w;
    logic [IDX_W-1:0]       cand;
    logic [DATA_SIZE-1:0]   sel_data;
    logic                   sel_last;
    logic                   load;
    logic                   accept;
    logic [IDX_W-1:0]       ptr_d;

    // Grant: the lock owner alone, otherwise first valid port at or after ptr.
    always_comb begin
        grant  = '0;
        sel    = '0;
        found  = 1'b0;
        cand_w = '0;
        cand   = '0;
        if (state_q == LOCKED) begin
            grant[owner_q] = 1'b1;
            sel            = owner_q;
        end else begin
            for (int off = 0; off < N_PORTS; off++) begin
                cand_w = {1'b0, ptr_q} + (IDX_W+1)'(off);
                if (cand_w >= (IDX_W+1)'(N_PORTS)) begin
                    cand_w = cand_w - (IDX_W+1)'(N_PORTS);
                end
                cand = cand_w[IDX_W-1:0];
                if (!found && in_valid[cand]) begin
                    found       = 1'b1;
                    grant[cand] = 1'b1;
                    sel         = cand;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    assign sel_last = |(in_last & grant);
    assign load     = !out_valid_q || out_ready;
    assign in_ready = (rst_n && load) ? grant : '0;
    assign accept   = |(in_valid & in_ready);
    assign ptr_d    = (sel == IDX_W'(N_PORTS - 1)) ? '0 : sel + IDX_W'(1);

    // Output register and arbitration state move only when the output can load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_port_q  <= '0;
        end else if (load) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= sel_data;
                out_last_q <= sel_last;
                out_port_q <= sel;
                case (state_q)
                    IDLE: begin
                        if (!sel_last) begin
                            state_q <= LOCKED;
                            owner_q <= sel;
                        end
                    end
                    LOCKED: begin
                        if (sel_last) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // Fairness is per packet: the pointer only moves past a finished packet.
                if (sel_last) begin
                    ptr_q <= ptr_d;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_port  = out_port_q;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: directed scenarios plus randomized traffic against a packet-level reference model.
module tb_stream_arbiter;

    localparam int DW = 8;
    localparam int NP = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  in_data;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic [IW-1:0]     out_port;
    logic              out_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock holds the port owning an open packet (-1 when none).
    int m_lock = -1;
    int m_ptr  = 0;
    bit m_ov   = 1'b0;
    bit m_ol   = 1'b0;
    int m_od   = 0;
    int m_op   = 0;

    stream_arbiter #(.DATA_SIZE(DW), .N_PORTS(NP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_port  (out_port),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (m_lock >= 0) return m_lock;
        for (int off = 0; off < NP; off++) begin
            int p = (m_ptr + off) % NP;
            if (in_valid[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [NP-1:0] m_ready();
        logic [NP-1:0] r = '0;
        int g = m_grant();
        if (rst_n && (!m_ov || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [1+1+IW+DW-1:0] m_out();
        return {m_ov, m_ol, IW'(m_op), DW'(m_od)};
    endfunction

    task automatic m_clock(output bit acc, output int g);
        acc = 1'b0;
        g   = -1;
        if (!rst_n) begin
            m_ov = 0; m_ol = 0; m_od = 0; m_op = 0; m_lock = -1; m_ptr = 0;
        end else if (!m_ov || out_ready) begin
            g    = m_grant();
            acc  = (g >= 0) && in_valid[g];
            m_ov = acc;
            if (acc) begin
                m_od = int'(in_data[g*DW +: DW]);
                m_ol = in_last[g];
                m_op = g;
                if (in_last[g]) begin
                    m_lock = -1;
                    m_ptr  = (g + 1) % NP;
                end else begin
                    m_lock = g;
                end
            end
        end
    endtask

    task automatic cycle(output bit acc, output int g);
        m_clock(acc, g);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit a; int g;
        rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
        cycle(a, g);
        cycle(a, g);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit a; int g;
        rst_n = 1'b0; in_valid = '1; in_last = '0; in_data = $urandom; out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== '0) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        cycle(a, g);
        n_checks++;
        if ({out_valid, out_last, out_port, out_data} !== '0)
            begin n_errors++; $display("FAIL reset_outputs got=%b/%b/%0d/%h exp=0/0/0/00", out_valid, out_last, out_port, out_data); end
        rst_n = 1'b1; in_valid = '0;
        cycle(a, g);
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        bit a; int g;
        int exp_port[5] = '{0, 1, 2, 3, 0};
        do_reset();
        in_valid = '1; in_last = '1; in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            cycle(a, g);
            n_checks++;
            if (out_valid !== 1'b1 || out_port !== IW'(exp_port[i]) || out_data !== DW'(8'hA0 + exp_port[i]))
                begin n_errors++; $display("FAIL rr_seq[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_port, out_data, exp_port[i], 8'hA0 + exp_port[i]); end
        end
    endtask

    task automatic test_lock();
        bit a; int g; int b = 0;
        int exp_port[4] = '{2, 2, 2, 0};
        int exp_data[4] = '{8'h11, 8'h12, 8'h13, 8'h0F};
        do_reset();
        out_ready = 1'b1; in_valid = 4'b0010; in_last = '1; in_data = '0;
        #1;
        cycle(a, g);
        for (int i = 0; i < 4; i++) begin
            in_valid = {1'b0, b < 3, 1'b0, 1'b1};
            in_last  = {1'b0, b == 2, 1'b0, 1'b1};
            in_data  = {8'h00, DW'(8'h11 + b), 8'h00, 8'h0F};
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL lock_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            if (i < 3) begin
                n_checks++;
                if (in_ready[0] !== 1'b0) begin n_errors++; $display("FAIL lock_port0_blocked[%0d] got=%b exp=0", i, in_ready[0]); end
            end
            cycle(a, g);
            if (a && g == 2) b++;
            n_checks++;
            if (out_valid !== 1'b1 || out_port !== IW'(exp_port[i]) || out_data !== DW'(exp_data[i]))
                begin n_errors++; $display("FAIL lock_seq[%0d] got=%0d/%h exp=%0d/%h", i, out_port, out_data, exp_port[i], exp_data[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit a; int g; int d = 8'h55; int exp_next = 8'h55;
        do_reset();
        in_valid = 4'b0001; in_last = '1; in_data = '0;
        for (int i = 0; i < 10; i++) begin
            out_ready = !(i >= 1 && i <= 4);
            in_data[DW-1:0] = DW'(d);
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            if (i >= 1 && i <= 4) begin
                n_checks++;
                if (in_ready !== '0 || out_data !== 8'h55 || out_valid !== 1'b1)
                    begin n_errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=0000/55/1", i, in_ready, out_data, out_valid); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== DW'(exp_next)) begin n_errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, out_data, DW'(exp_next)); end
                exp_next++;
            end
            cycle(a, g);
            if (a) d++;
            n_checks++;
            if ({out_valid, out_last, out_port, out_data} !== m_out())
                begin n_errors++; $display("FAIL bp_out[%0d] got=%h exp=%h", i, {out_valid, out_last, out_port, out_data}, m_out()); end
        end
    endtask

    task automatic test_owner_gap();
        bit a; int g; int b = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = {(i == 0 || i >= 3) && b < 3, 1'b0, i >= 1, 1'b0};
            in_last  = {b == 2, 1'b0, 1'b1, 1'b0};
            in_data  = {DW'(8'h30 + b), 8'h00, 8'h10, 8'h00};
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL gap_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            if (b < 3) begin
                n_checks++;
                if (in_ready[1] !== 1'b0) begin n_errors++; $display("FAIL gap_port1_blocked[%0d] got=%b exp=0", i, in_ready[1]); end
            end
            cycle(a, g);
            if (a && g == 3) b++;
            if (i == 1 || i == 2) begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_errors++; $display("FAIL gap_bubble[%0d] got=%b exp=0", i, out_valid); end
            end
            n_checks++;
            if ({out_valid, out_last, out_port, out_data} !== m_out())
                begin n_errors++; $display("FAIL gap_out[%0d] got=%h exp=%h", i, {out_valid, out_last, out_port, out_data}, m_out()); end
        end
    endtask

    task automatic test_reset_locked();
        bit a; int g;
        do_reset();
        out_ready = 1'b1; in_valid = 4'b0100; in_last = '0; in_data = {8'h00, 8'h21, 8'h00, 8'h00};
        #1;
        cycle(a, g);
        in_valid = '1; out_ready = 1'b0; rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== '0) begin n_errors++; $display("FAIL rstlock_ready got=%b exp=0000", in_ready); end
        cycle(a, g);
        n_checks++;
        if ({out_valid, out_last, out_port, out_data} !== '0)
            begin n_errors++; $display("FAIL rstlock_out got=%b/%0d/%h exp=0/0/00", out_valid, out_port, out_data); end
        rst_n = 1'b1; in_last = '1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_errors++; $display("FAIL rstlock_grant got=%b exp=0001", in_ready); end
        cycle(a, g);
        n_checks++;
        if (out_valid !== 1'b1 || out_port !== 2'd0) begin n_errors++; $display("FAIL rstlock_port got=%b/%0d exp=1/0", out_valid, out_port); end
    endtask

    task automatic test_pipe_fill();
        bit a; int g; int sent = 0;
        logic [DW-1:0] pipe[$];
        do_reset();
        in_valid = '0; in_last = '1; in_data = '0;
        for (int i = 0; i < 9; i++) begin
            in_valid[0]     = sent < 6;
            in_data[DW-1:0] = DW'(8'hC0 + sent);
            out_ready       = pipe.size() < 4;
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL pipe_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            if (out_valid && out_ready) pipe.push_back(out_data);
            cycle(a, g);
            if (a) sent++;
        end
        out_ready = pipe.size() < 4;
        #1;
        n_checks++;
        if (pipe.size() != 4 || sent != 5) begin n_errors++; $display("FAIL pipe_count got=%0d/%0d exp=4/5", pipe.size(), sent); end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC4 || in_ready !== '0)
            begin n_errors++; $display("FAIL pipe_stall got=%b/%h/%b exp=1/c4/0000", out_valid, out_data, in_ready); end
        for (int k = 0; k < pipe.size(); k++) begin
            n_checks++;
            if (pipe[k] !== DW'(8'hC0 + k)) begin n_errors++; $display("FAIL pipe_data[%0d] got=%h exp=%h", k, pipe[k], DW'(8'hC0 + k)); end
        end
    endtask

    task automatic test_random();
        bit a; int g; bit hold; logic [DW+IW:0] prev;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n     = $urandom_range(0, 79) != 0;
            in_valid  = NP'($urandom);
            in_last   = NP'($urandom) & NP'($urandom);
            in_data   = $urandom;
            out_ready = $urandom_range(0, 9) < 7;
            #1;
            n_checks++;
            if (in_ready !== m_ready()) begin n_errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, m_ready()); end
            hold = rst_n && out_valid && !out_ready;
            prev = {out_data, out_last, out_port};
            cycle(a, g);
            n_checks++;
            if ({out_valid, out_last, out_port, out_data} !== m_out())
                begin n_errors++; $display("FAIL rand_out[%0d] got=%h exp=%h", i, {out_valid, out_last, out_port, out_data}, m_out()); end
            if (hold) begin
                n_checks++;
                if ({out_data, out_last, out_port} !== prev || out_valid !== 1'b1)
                    begin n_errors++; $display("FAIL rand_hold[%0d] got=%h exp=%h", i, {out_data, out_last, out_port}, prev); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_owner_gap();
        test_reset_locked();
        test_pipe_fill();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 8, SHALL set the payload width in bits of each input and of the output.
REQ-002 Parameter N_PORTS, default 4, SHALL set the number of requesters and SHALL be >= 2; IDX_W = clog2(N_PORTS).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_data  input  N_PORTS*DATA_SIZE  SHALL carry the payloads; port i occupies bits [i*DATA_SIZE +: DATA_SIZE].
REQ-006 in_valid  input  N_PORTS  SHALL mark each port's beat as valid.
REQ-007 in_last  input  N_PORTS  SHALL mark each port's beat as the final beat of a packet.
REQ-008 in_ready  output  N_PORTS  SHALL signal per-port beat acceptance.
REQ-009 out_data  output  DATA_SIZE  SHALL carry the registered payload to the downstream FIFO.
REQ-010 out_valid  output  1  SHALL mark out_data as valid.
REQ-011 out_last  output  1  SHALL carry the registered last flag.
REQ-012 out_port  output  IDX_W  SHALL carry the index of the source port of the current output beat.
REQ-013 out_ready  input  1  SHALL signal downstream acceptance; it connects to the enq_ready of a pipe instance.

Function
REQ-014 A transfer on port i SHALL occur on a cycle where in_valid[i] && in_ready[i]; the output transfer SHALL occur where out_valid && out_ready.
REQ-015 Output register load enable SHALL be load = !out_valid || out_ready.
REQ-016 in_ready[i] SHALL equal load && grant[i]; at most one bit of in_ready SHALL be high per cycle.
REQ-017 Latency SHALL be 1 cycle: a beat accepted in cycle t SHALL appear on out_* in cycle t+1.
REQ-018 With a continuously ready sink and a continuously valid source, throughput SHALL be one beat per cycle with no bubbles.
REQ-019 While out_valid && !out_ready, out_data, out_last and out_port SHALL hold stable.
REQ-020 The FSM SHALL have two states, IDLE and LOCKED; the current lock owner SHALL be held in register owner.
REQ-021 In IDLE, grant SHALL go to the first requesting port found by a round-robin search starting at index ptr and wrapping from N_PORTS-1 to 0.
REQ-022 In IDLE, an accepted beat with in_last=0 from port k SHALL move the FSM to LOCKED with owner=k.
REQ-023 In IDLE, an accepted beat with in_last=1 SHALL leave the FSM in IDLE.
REQ-024 In LOCKED, grant SHALL be owner only; other ports SHALL see in_ready=0 even if the owner is not valid.
REQ-025 In LOCKED, an accepted owner beat with in_last=1 SHALL return the FSM to IDLE.
REQ-026 ptr SHALL update to (k+1) mod N_PORTS only when a beat with in_last=1 from port k is accepted, so fairness is per packet.
REQ-027 When no port requests in IDLE, or when load=0, no input SHALL be accepted, and ptr, the FSM and owner SHALL hold.
REQ-028 If load=1 and no beat is accepted, out_valid SHALL go to 0 on the next cycle.
REQ-029 Changes to in_valid or in_data on non-granted ports SHALL have no effect on any state.

Reset
REQ-030 When rst_n=0 at a clock edge, the following SHALL be set regardless of any in-flight packet or pending beat: out_valid=0, out_data=0, out_last=0, out_port=0, FSM=IDLE, owner=0, ptr=0.
REQ-031 in_ready SHALL be combinationally 0 while rst_n=0.
REQ-032 A beat held in the output register at reset SHALL be discarded, not delivered.

Verification
REQ-033 Case: reset, then ports 0..3 all valid with single-beat packets (last=1) data 0xA0..0xA3, out_ready=1 -> out_port sequence is 0,1,2,3,0 on consecutive cycles with no gaps.
REQ-034 Case: port 2 sends a 3-beat packet 0x11,0x12,0x13 (last on the third beat) while port 0 is valid throughout -> the three port-2 beats are contiguous on the output, then port 0 follows, and port 0's in_ready=0 during the lock.
REQ-035 Case: out_ready held 0 for 4 cycles with out_valid=1 and data 0x55 -> out_data stays 0x55, all in_ready=0, no input is lost, and the stream resumes in order when out_ready returns to 1.
REQ-036 Case: the owner drops in_valid for 2 cycles mid-packet while port 1 is valid -> out_valid goes to 0 and port 1 is not granted until the owner's last beat is accepted.
REQ-037 Case: rst_n asserted for 1 cycle in LOCKED with out_valid=1 -> out_valid=0 next cycle, FSM=IDLE, and the next grant goes to port 0.
REQ-038 Case: stream_arbiter connected to a pipe with DEPTH=4, pipe deq_ready=0, 6 single-beat requests -> 4 beats stored in the pipe, 1 beat held in the output register, and the 6th beat stalls with in_ready=0.
